// File: rtl/bus_timer.sv
// Memory-mapped 16-bit down-counting interval timer with prescaler and interrupt.
// Latency: register writes take effect one cycle after the strobe; reads are combinational; int_b lags EXP/IE by one cycle.
// Backpressure: none; every strobed access completes in a single cycle.
module bus_timer #(
  parameter int PRESCALE = 32,
  parameter int PRE_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] din,
  output logic [15:0] dout,
  input  logic [1:0]  a,
  input  logic        rnw,
  input  logic        cs_b,
  output logic        int_b
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [15:0]      r_count;
  logic [15:0]      r_reload;
  logic             r_en;
  logic             r_ie;
  logic             r_auto;
  logic             r_exp;
  logic [PRE_W-1:0] r_pre;
  logic             r_int_b;

  logic w_wr;
  logic w_wr_count;
  logic w_wr_reload;
  logic w_wr_ctrl;
  logic w_wr_status;
  logic w_tick;
  logic w_tick_live;
  logic w_expire;

  assign w_wr        = !cs_b && !rnw;
  assign w_wr_count  = w_wr && (a == 2'd0);
  assign w_wr_reload = w_wr && (a == 2'd1);
  assign w_wr_ctrl   = w_wr && (a == 2'd2);
  assign w_wr_status = w_wr && (a == 2'd3);

  assign w_tick      = r_en && (r_pre == PRE_MAX);
  // A COUNT write in the same cycle swallows the tick entirely.
  assign w_tick_live = w_tick && !w_wr_count;
  assign w_expire    = w_tick_live && (r_count == 16'd0);

  assign int_b = r_int_b;

  // Read mux: selected by address alone; the system top gates it with chip select.
  always_comb begin
    dout = 16'h0000;
    case (a)
      2'd0: dout = r_count;
      2'd1: dout = r_reload;
      2'd2: dout = {13'd0, r_auto, r_ie, r_en};
      2'd3: dout = {15'd0, r_exp};
      default: dout = 16'h0000;
    endcase
  end

  // Timer state: prescaler, counter, expiry, register writes and the registered interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= 16'h0000;
      r_reload <= 16'h0000;
      r_en     <= 1'b0;
      r_ie     <= 1'b0;
      r_auto   <= 1'b0;
      r_exp    <= 1'b0;
      r_pre    <= '0;
      r_int_b  <= 1'b1;
    end else begin
      // Prescaler holds at zero while disabled and wraps on tick.
      if (!r_en || w_tick) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end

      if (w_tick_live) begin
        if (r_count != 16'd0) begin
          r_count <= r_count - 16'd1;
        end else if (r_auto) begin
          r_count <= r_reload;
        end else begin
          // One-shot: stop; a CTRL write below in the same cycle overrides this.
          r_en <= 1'b0;
        end
      end

      if (w_wr_count) begin
        r_count <= din;
        r_pre   <= '0;
      end

      if (w_wr_reload) begin
        r_reload <= din;
      end

      if (w_wr_ctrl) begin
        r_en   <= din[0];
        r_ie   <= din[1];
        r_auto <= din[2];
        // Restart the prescaler on enable; a re-write of EN=1 leaves it running.
        if (!r_en || !din[0]) begin
          r_pre <= '0;
        end
      end

      // Expiry wins over a same-cycle write-1-to-clear.
      if (w_expire) begin
        r_exp <= 1'b1;
      end else if (w_wr_status && din[0]) begin
        r_exp <= 1'b0;
      end

      r_int_b <= !(r_exp && r_ie);
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer with PRESCALE=4.
// Latency: inputs change 1 time unit after the rising edge; outputs sampled mid-cycle.
// Backpressure: not applicable.
module tb_bus_timer;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic [15:0] dout;
  logic [1:0]  a;
  logic        rnw;
  logic        cs_b;
  logic        int_b;

  int checks;
  int failures;

  bus_timer #(.PRESCALE(4), .PRE_W(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .dout  (dout),
    .a     (a),
    .rnw   (rnw),
    .cs_b  (cs_b),
    .int_b (int_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %04h expected %04h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single-cycle write strobe; the write lands on the next rising edge.
  task automatic wr(input logic [1:0] addr, input logic [15:0] data);
    a    = addr;
    din  = data;
    rnw  = 1'b0;
    cs_b = 1'b0;
    @(posedge clk);
    #1;
    cs_b = 1'b1;
    rnw  = 1'b1;
  endtask

  task automatic rd(input logic [1:0] addr, output logic [15:0] data);
    a = addr;
    #1;
    data = dout;
  endtask

  logic [15:0] v;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    din      = 16'h0000;
    a        = 2'd0;
    rnw      = 1'b1;
    cs_b     = 1'b1;

    // Reset state
    step(2);
    reset = 1'b0;
    step(1);
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), v);
      chk($sformatf("reset_reg%0d", i), v, 16'h0000);
    end
    chk("reset_int_b", {15'd0, int_b}, 16'h0001);

    // Auto-reload: period (3+1)*4 = 16 cycles after the CTRL write edge
    wr(2'd1, 16'h0003);
    wr(2'd0, 16'h0003);
    wr(2'd2, 16'h0007);
    step(4);
    rd(2'd0, v); chk("auto_cnt_4", v, 16'h0002);
    step(4);
    rd(2'd0, v); chk("auto_cnt_8", v, 16'h0001);
    step(4);
    rd(2'd0, v); chk("auto_cnt_12", v, 16'h0000);
    rd(2'd3, v); chk("auto_exp_12", v, 16'h0000);
    step(3);
    rd(2'd3, v); chk("auto_exp_15", v, 16'h0000);
    step(1);
    rd(2'd3, v); chk("auto_exp_16", v, 16'h0001);
    rd(2'd0, v); chk("auto_reload_16", v, 16'h0003);
    chk("auto_int_b_16", {15'd0, int_b}, 16'h0001);
    step(1);
    chk("auto_int_b_17", {15'd0, int_b}, 16'h0000);

    // Write-1-clear at edge 18, interrupt drops one cycle later
    wr(2'd3, 16'h0001);
    rd(2'd3, v); chk("clr_exp", v, 16'h0000);
    chk("clr_int_b_lag", {15'd0, int_b}, 16'h0000);
    step(1);
    chk("clr_int_b", {15'd0, int_b}, 16'h0001);

    // Clear landing on the expiry edge (32): set wins
    step(12);
    wr(2'd3, 16'h0001);
    rd(2'd3, v); chk("clr_on_expiry", v, 16'h0001);
    step(1);
    chk("int_b_before_reset", {15'd0, int_b}, 16'h0000);

    // Reset mid-count with interrupt pending
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), v);
      chk($sformatf("midrst_reg%0d", i), v, 16'h0000);
    end
    chk("midrst_int_b", {15'd0, int_b}, 16'h0001);
    step(20);
    rd(2'd3, v); chk("midrst_no_tick", v, 16'h0000);

    // One-shot: COUNT=2, EN|IE -> expiry 12 cycles after the CTRL write
    wr(2'd0, 16'h0002);
    wr(2'd2, 16'h0003);
    step(11);
    rd(2'd3, v); chk("oneshot_exp_11", v, 16'h0000);
    step(1);
    rd(2'd3, v); chk("oneshot_exp_12", v, 16'h0001);
    rd(2'd2, v); chk("oneshot_ctrl", v, 16'h0002);
    rd(2'd0, v); chk("oneshot_cnt", v, 16'h0000);
    step(1);
    chk("oneshot_int_b", {15'd0, int_b}, 16'h0000);
    wr(2'd3, 16'h0001);
    step(100);
    rd(2'd3, v); chk("oneshot_no_rearm", v, 16'h0000);
    rd(2'd0, v); chk("oneshot_cnt_hold", v, 16'h0000);
    chk("oneshot_int_b_idle", {15'd0, int_b}, 16'h0001);

    // COUNT write on the exact tick edge beats the decrement
    wr(2'd0, 16'h0009);
    wr(2'd2, 16'h0001);
    step(4);
    rd(2'd0, v); chk("tick_cnt_first", v, 16'h0008);
    step(3);
    wr(2'd0, 16'h0005);
    rd(2'd0, v); chk("tick_wr_wins", v, 16'h0005);
    step(3);
    rd(2'd0, v); chk("tick_wr_hold", v, 16'h0005);
    step(1);
    rd(2'd0, v); chk("tick_wr_next", v, 16'h0004);
    rd(2'd3, v); chk("tick_wr_no_exp", v, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
